// File: rtl/divider_pkg.sv
// Shared constants and FSM encoding for the divider controller.
// Imported by divider_channel and divider_controller.
package divider_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int WIDTH_DEF = 32;

  // Width of the cfg_chan port; wide enough for up to 8 channels.
  localparam int CHAN_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/divider_channel.sv
// One programmable divider: half-period, enable, counter, out, tick.
// Ports: in/reset, load+half_in+en_in (atomic write), sync, out, tick.
module divider_channel
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] half_in,
  input  logic             en_in,
  input  logic             sync,
  output logic             out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt;
  logic             en;

  always_ff @(posedge in or posedge reset) begin
    if (reset) begin
      half <= '0;
      en   <= 1'b0;
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
    end else if (load) begin
      // H=0 would never match; run it as H=1.
      half <= (half_in == '0) ? ONE : half_in;
      en   <= en_in;
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
    end else if (!en || sync) begin
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
    end else if (cnt == half - ONE) begin
      cnt  <= '0;
      out  <= ~out;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + ONE;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/divider_controller.sv
// Bank of CHANNELS dividers written via a valid/ready config port.
// Ports: in/reset, cfg_valid/ready/chan/half/en, sync, out, tick.
module divider_controller
  import divider_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                in,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_half,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);

  state_t state;
  state_t state_nx;

  logic [CHAN_W-1:0] stg_chan;
  logic [WIDTH-1:0]  stg_half;
  logic              stg_en;
  logic              accept;
  logic [CHANNELS-1:0] load;

  always_ff @(posedge in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = ~reset;
        if (cfg_valid) state_nx = APPLY;
      end
      APPLY: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign accept = cfg_valid && (state == IDLE);

  always_ff @(posedge in or posedge reset) begin
    if (reset) begin
      stg_chan <= '0;
      stg_half <= '0;
      stg_en   <= 1'b0;
    end else if (accept) begin
      stg_chan <= cfg_chan;
      stg_half <= cfg_half;
      stg_en   <= cfg_en;
    end
  end

  // Full-width compare: indices >= CHANNELS load nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load[i] = (state == APPLY) &&
                     (stg_chan == CHAN_W'(i));

    divider_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .in     (in),
      .reset  (reset),
      .load   (load[i]),
      .half_in(stg_half),
      .en_in  (stg_en),
      .sync   (sync),
      .out    (out[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_divider_controller.sv
// Directed self-checking bench for divider_controller.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_divider_controller;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_chan;
  logic [31:0] cfg_half;
  logic        cfg_en;
  logic        sync;
  logic [3:0]  out;
  logic [3:0]  tick;

  int tests = 0;
  int fails = 0;

  divider_controller #(
    .CHANNELS(4),
    .WIDTH(32)
  ) dut (
    .in       (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_half (cfg_half),
    .cfg_en   (cfg_en),
    .sync     (sync),
    .out      (out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Returns 1 unit after the accept edge (FSM in APPLY).
  task automatic do_write(input logic [2:0] ch,
                          input logic [31:0] h,
                          input logic e);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_half  = h;
    cfg_en    = e;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL wr_ready_pre ch%0d: got %b exp 1", ch, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL wr_ready_apply ch%0d: got %b exp 0", ch, cfg_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({cfg_ready, out, tick} !== 9'd0) begin
        fails++;
        $display("FAIL reset_hold c%0d: rdy=%b out=%b tick=%b exp 0",
                 i, cfg_ready, out, tick);
      end
    end
    reset = 1'b0;
    #1;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b exp 1", cfg_ready);
    end
  endtask

  task automatic test_basic();
    logic eo;
    logic et;
    do_write(3'd0, 32'd3, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      step();
      eo = (j >= 4 && j < 7);
      et = (j == 4 || j == 7);
      tests++;
      if (out[0] !== eo || tick[0] !== et) begin
        fails++;
        $display("FAIL basic_h3 k+%0d: out=%b tick=%b exp out=%b tick=%b",
                 j, out[0], tick[0], eo, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hs [4];
    logic p3;
    logic p0;
    hs[0] = 32'd1;
    hs[1] = 32'd2;
    hs[2] = 32'd5;
    hs[3] = 32'd0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_chan = 3'(i);
      cfg_half = hs[i];
      cfg_en   = 1'b1;
      tests++;
      if (cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready_idle w%0d: got %b exp 1", i, cfg_ready);
      end
      step();
      tests++;
      if (cfg_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ready_apply w%0d: got %b exp 0", i, cfg_ready);
      end
      if (i < 3) step();
    end
    cfg_valid = 1'b0;
    step();
    step();
    p3 = out[3];
    p0 = out[0];
    for (int j = 0; j < 6; j++) begin
      step();
      tests++;
      if (out[3] !== ~p3 || tick[3] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_h0_ch3 c%0d: out=%b tick=%b exp out=%b tick=1",
                 j, out[3], tick[3], ~p3);
      end
      tests++;
      if (out[0] !== ~p0 || tick[0] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_h1_ch0 c%0d: out=%b tick=%b exp out=%b tick=1",
                 j, out[0], tick[0], ~p0);
      end
      p3 = out[3];
      p0 = out[0];
    end
  endtask

  task automatic test_sync();
    logic e;
    do_reset();
    do_write(3'd1, 32'd4, 1'b1);
    repeat (6) step();
    tests++;
    if (out[1] !== 1'b1) begin
      fails++;
      $display("FAIL sync_pre: out1=%b exp 1", out[1]);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    tests++;
    if (out[1] !== 1'b0 || tick[1] !== 1'b0 || out[2] !== 1'b0) begin
      fails++;
      $display("FAIL sync_edge: out1=%b tick1=%b out2=%b exp 0 0 0",
               out[1], tick[1], out[2]);
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      e = (j == 4);
      tests++;
      if (out[1] !== e || tick[1] !== e || out[2] !== 1'b0) begin
        fails++;
        $display("FAIL sync_after s+%0d: out1=%b tick1=%b out2=%b exp %b %b 0",
                 j, out[1], tick[1], out[2], e, e);
      end
    end
  endtask

  task automatic test_disable();
    int n2;
    int n1;
    do_write(3'd2, 32'd2, 1'b1);
    n2 = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      n2 += int'(tick[2]);
    end
    tests++;
    if (n2 != 2) begin
      fails++;
      $display("FAIL dis_running: ticks=%0d exp 2", n2);
    end
    do_write(3'd2, 32'd2, 1'b0);
    step();
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (out[2] !== 1'b0 || tick[2] !== 1'b0) begin
        fails++;
        $display("FAIL dis_off c%0d: out2=%b tick2=%b exp 0 0",
                 j, out[2], tick[2]);
      end
      step();
    end
    do_write(3'd6, 32'd7, 1'b1);
    n1 = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      n1 += int'(tick[1]);
      tests++;
      if (out[2] !== 1'b0 || tick[2] !== 1'b0 ||
          out[0] !== 1'b0 || out[3] !== 1'b0) begin
        fails++;
        $display("FAIL oob_chan c%0d: out=%b tick=%b exp out[0,2,3]=0",
                 j, out, tick);
      end
    end
    tests++;
    if (n1 != 3) begin
      fails++;
      $display("FAIL oob_ch1_ticks: got %0d exp 3", n1);
    end
  endtask

  task automatic test_reset_apply();
    do_write(3'd0, 32'd1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({cfg_ready, out, tick} !== 9'd0) begin
      fails++;
      $display("FAIL rst_apply_async: rdy=%b out=%b tick=%b exp 0",
               cfg_ready, out, tick);
    end
    step();
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_apply_ready: got %b exp 1", cfg_ready);
    end
    for (int j = 0; j < 5; j++) begin
      step();
      tests++;
      if (out !== 4'd0 || tick !== 4'd0) begin
        fails++;
        $display("FAIL rst_apply_aborted c%0d: out=%b tick=%b exp 0",
                 j, out, tick);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = 3'd0;
    cfg_half  = 32'd0;
    cfg_en    = 1'b0;
    sync      = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_sync();
    test_disable();
    test_reset_apply();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
